// File: rtl/m_store_stage.sv
// m_store_stage: MIPS memory stage -- store decode, byte enables, data memory, M/W pipeline register
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   IR_M, AO_M, RT_M    : M-stage instruction, effective byte address, forwarded store data
//   pc4_M               : PC+4 of the M-stage instruction
//   IR_W, AO_W, pc4_W   : registered copies for the writeback stage
//   DR_W                : registered aligned word read at AO_M (0 when out of range)
//   dm_be               : combinational byte enables of the current store (0 if none or illegal)
//   addr_err            : registered flag, previous M instruction was an illegal store
module m_store_stage #(
  parameter int DM_WORDS = 1024,
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IR_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RT_M,
  input  logic [31:0] pc4_M,
  output logic [31:0] IR_W,
  output logic [31:0] AO_W,
  output logic [31:0] pc4_W,
  output logic [31:0] DR_W,
  output logic [3:0]  dm_be,
  output logic        addr_err
);
  logic [31:0] mem [DM_WORDS];
  logic [5:0]  op;
  logic        is_sw, is_sh, is_sb, is_store, in_range, aligned, illegal;
  logic [3:0]  raw_be;
  logic [31:0] wdata, rdata;
  logic [AW-1:0] idx;
  assign op       = IR_M[31:26];
  assign is_sw    = op == 6'b101011;
  assign is_sh    = op == 6'b101001;
  assign is_sb    = op == 6'b101000;
  assign is_store = is_sw | is_sh | is_sb;
  assign in_range = AO_M[31:AW+2] == '0;
  assign aligned  = is_sw ? AO_M[1:0] == 2'b00 : is_sh ? !AO_M[0] : 1'b1;
  assign illegal  = is_store && !(in_range && aligned);
  assign raw_be   = is_sw ? 4'b1111 : is_sh ? (AO_M[1] ? 4'b1100 : 4'b0011) :
                    is_sb ? 4'b0001 << AO_M[1:0] : 4'b0000;
  assign dm_be    = illegal ? 4'b0000 : raw_be;
  assign wdata    = is_sw ? RT_M : is_sh ? {2{RT_M[15:0]}} : {4{RT_M[7:0]}};
  assign idx      = AO_M[AW+1:2];
  assign rdata    = in_range ? mem[idx] : 32'h0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IR_W     <= '0;
      AO_W     <= '0;
      pc4_W    <= '0;
      DR_W     <= '0;
      addr_err <= 1'b0;
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else begin
      IR_W     <= IR_M;
      AO_W     <= AO_M;
      pc4_W    <= pc4_M;
      DR_W     <= rdata;
      addr_err <= illegal;
      for (int i = 0; i < 4; i++)
        if (dm_be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_m_store_stage.sv
// tb_m_store_stage: directed-vector bench for m_store_stage
module tb_m_store_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] IR_M = '0, AO_M = '0, RT_M = '0, pc4_M = '0;
  logic [31:0] IR_W, AO_W, pc4_W, DR_W;
  logic [3:0]  dm_be;
  logic        addr_err;
  int checks = 0, errors = 0;
  localparam logic [31:0] SW = 32'hAC000000, SH = 32'hA4000000, SB = 32'hA0000000, LW = 32'h8C000000;
  m_store_stage dut (
    .clk(clk), .reset_n(reset_n), .IR_M(IR_M), .AO_M(AO_M), .RT_M(RT_M), .pc4_M(pc4_M),
    .IR_W(IR_W), .AO_W(AO_W), .pc4_W(pc4_W), .DR_W(DR_W), .dm_be(dm_be), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [31:0] ir, ao, rt, pc, input logic [3:0] be_exp, input string tag);
    IR_M = ir; AO_M = ao; RT_M = rt; pc4_M = pc;
    #1 chk({tag, "_be"}, {28'h0, dm_be}, {28'h0, be_exp});
    @(posedge clk);
    #1;
  endtask
  initial begin
    IR_M = LW; AO_M = 32'h0; pc4_M = 32'h4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", IR_W, 32'h0);
    chk("rst_pc4", pc4_W, 32'h0);
    chk("rst_dr", DR_W, 32'h0);
    chk("rst_err", {31'h0, addr_err}, 32'h0);
    reset_n = 1'b1;
    step(LW, 32'h0, 32'h0, 32'h4, 4'b0000, "lw0");
    chk("lw0_dr", DR_W, 32'h0);
    chk("lw0_ir", IR_W, LW);
    step(SW, 32'h10, 32'h12345678, 32'h8, 4'b1111, "sw10");
    step(LW, 32'h10, 32'h0, 32'hC, 4'b0000, "lw10");
    chk("lw10_dr", DR_W, 32'h12345678);
    step(SW, 32'h20, 32'hAABBCCDD, 32'h10, 4'b1111, "sw20");
    step(SB, 32'h23, 32'h000000EE, 32'h14, 4'b1000, "sb23");
    step(SH, 32'h20, 32'h00001122, 32'h18, 4'b0011, "sh20");
    step(LW, 32'h20, 32'h0, 32'h1C, 4'b0000, "lw20");
    chk("merge_dr", DR_W, 32'hEEBB1122);
    step(SB, 32'h21, 32'h00000055, 32'h20, 4'b0010, "sb21");
    step(LW, 32'h20, 32'h0, 32'h24, 4'b0000, "lw20b");
    chk("sb21_dr", DR_W, 32'hEEBB5522);
    step(SW, 32'h30, 32'hCAFEBABE, 32'h28, 4'b1111, "sw30");
    chk("sw30_err", {31'h0, addr_err}, 32'h0);
    step(SW, 32'h31, 32'h11111111, 32'h2C, 4'b0000, "sw31");
    chk("sw31_err", {31'h0, addr_err}, 32'h1);
    step(SH, 32'h33, 32'h22222222, 32'h30, 4'b0000, "sh33");
    chk("sh33_err", {31'h0, addr_err}, 32'h1);
    step(LW, 32'h30, 32'h0, 32'h34, 4'b0000, "lw30");
    chk("lw30_err", {31'h0, addr_err}, 32'h0);
    chk("lw30_dr", DR_W, 32'hCAFEBABE);
    step(SW, 32'h0, 32'h0BADF00D, 32'h38, 4'b1111, "sw0");
    step(SW, 32'h1000, 32'hDEADBEEF, 32'h3C, 4'b0000, "swoor");
    chk("swoor_err", {31'h0, addr_err}, 32'h1);
    step(LW, 32'h0, 32'h0, 32'h40, 4'b0000, "lw0b");
    chk("lw0b_dr", DR_W, 32'h0BADF00D);
    chk("lw0b_err", {31'h0, addr_err}, 32'h0);
    step(LW, 32'h1000, 32'h0, 32'h44, 4'b0000, "lwoor");
    chk("lwoor_dr", DR_W, 32'h0);
    chk("lwoor_err", {31'h0, addr_err}, 32'h0);
    step(32'h8C880004, 32'h44, 32'h0, 32'h3010, 4'b0000, "pass");
    chk("pass_ir", IR_W, 32'h8C880004);
    chk("pass_ao", AO_W, 32'h44);
    chk("pass_pc4", pc4_W, 32'h3010);
    IR_M = LW; AO_M = 32'h10; pc4_M = 32'h50;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ir", IR_W, 32'h0);
    chk("arst_ao", AO_W, 32'h0);
    chk("arst_pc4", pc4_W, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(LW, 32'h10, 32'h0, 32'h54, 4'b0000, "lwclr");
    chk("lwclr_dr", DR_W, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_store_stage.md
Name: m_store_stage

Overview:
- Memory-stage block of the 5-stage MIPS pipeline; the store-side counterpart of the writeback byte extractor.
- Decodes the store type from IR_M and generates byte enables from the low address bits. It replicates store data into lanes and writes the on-chip data memory.
- Reads the addressed word for loads and registers IR/DR/AO/pc4 into the M/W pipeline register that feeds the writeback stage.
- Loads need the full aligned word in DR_W; writeback performs byte/half extraction.

Parameters:
- DM_WORDS, 1024, data memory depth in 32-bit words (4 KiB). Must be a power of 2.
- AW, 10, word-address width, log2(DM_WORDS). Word index = AO_M[AW+1:2].

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- IR_M  input  32  instruction in M stage.
- AO_M  input  32  ALU result, the effective byte address for loads/stores.
- RT_M  input  32  store data, already forwarded.
- pc4_M  input  32  PC+4 of M instruction.
- IR_W  output  32  registered IR_M.
- AO_W  output  32  registered AO_M.
- pc4_W  output  32  registered pc4_M.
- DR_W  output  32  registered aligned word read from memory at AO_M.
- dm_be  output  4  combinational byte enable of the current M instruction (0 if no write).
- addr_err  output  1  registered: previous M instruction was a misaligned or out-of-range store.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - IR_W, AO_W, pc4_W, DR_W and addr_err go to 0 immediately.
  - All DM_WORDS memory words are cleared to 0.
  - No write is performed while reset_n=0.
  - First write is possible on the first rising edge after reset_n goes high.
  - Reset mid-store cancels that store.
- Store decode from IR_M[31:26]:
  - sw 101011: be=1111, wdata=RT_M.
  - sh 101001: be = AO_M[1] ? 1100 : 0011, wdata={2{RT_M[15:0]}}.
  - sb 101000: be = 0001<<AO_M[1:0], wdata={4{RT_M[7:0]}}.
  - Any other opcode: be=0000, no write.
- Legality check (a store that fails it is illegal):
  - sw needs AO_M[1:0]=00.
  - sh needs AO_M[0]=0.
  - AO_M[31:AW+2] must be 0.
- Illegal store:
  - dm_be forced to 0000; memory unchanged.
  - addr_err=1 for exactly one cycle, registered at the same edge the instruction moves to W.
- Write:
  - At a rising edge, each byte lane i with dm_be[i]=1 is written with wdata[8i+7:8i] at word index AO_M[AW+1:2].
  - Lanes with dm_be[i]=0 keep their value.
  - Latency is 1 cycle: a load issued in the next cycle reads the new data.
- Read:
  - The word at AO_M[AW+1:2] is read combinationally and captured into DR_W at the rising edge.
  - Read-before-write: if the same edge writes that word, DR_W gets the old value. A single instruction never both loads and stores, so this case is harmless.
  - Out-of-range load address: DR_W=0, addr_err unaffected. Load alignment is checked elsewhere.
- Pipeline register:
  - Every rising edge, IR_W<=IR_M, AO_W<=AO_M, pc4_W<=pc4_M.
  - No stall or flush inputs; M->W always advances. A bubble is IR_M=0 (sll $0), which writes nothing.
- Simultaneous events: consecutive stores to the same word in back-to-back cycles apply in order. Byte merges accumulate, e.g. sb to lane 0 then sb to lane 3 leaves both bytes written.
- Address wrap: none; out-of-range is an error, never wrapped.

Test Plan:
- Reset, then lw at 0x00 -> DR_W=0x00000000; IR_W/AO_W/pc4_W=0 while reset_n=0. Assert reset_n=0 asynchronously mid-cycle -> outputs drop before the next edge.
- sw RT=0x12345678 @0x10, next cycle lw @0x10 -> dm_be=1111 during sw; DR_W=0x12345678 after the lw edge.
- Byte/half merge:
  - Stimulus: sw 0xAABBCCDD @0x20, then sb RT=0x000000EE @0x23, then sh RT=0x00001122 @0x20, then lw @0x20.
  - Enables: sb dm_be=1000, sh dm_be=0011.
  - Final DR_W=0xEEBB1122.
- Misaligned store: sw @0x31 and sh @0x33 -> dm_be=0000, addr_err=1 one cycle each. A later lw @0x30 returns the prior content unchanged.
- Out-of-range: sw @0x00001000 (DM_WORDS=1024) -> no write, addr_err=1. Word 0 is still intact on a lw @0x0.
- Pipeline pass-through: IR_M=0x8C880004, AO_M=0x44, pc4_M=0x3010 -> next edge IR_W, AO_W and pc4_W equal these values; non-store opcode -> dm_be=0000.
